// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: PID codes, SYNC pattern, tx FSM state and
// line-symbol types, and the CRC5 used by the token sender and token checker.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;

    // Field value sent LSB first: seven zeros then a one.
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_STUFF,
        TX_EOP0,
        TX_EOP1,
        TX_EOP_J
    } tx_state_e;

    typedef enum logic [1:0] {
        SYM_IDLE,
        SYM_BIT,
        SYM_SE0,
        SYM_J
    } line_sym_e;

    // data[0] is the first bit on the wire. The inverted remainder goes out
    // MSB first, so it is bit-reversed here to form an LSB-first field.
    function automatic logic [4:0] crc5(input logic [10:0] data);
        logic [4:0] crc;
        logic       fb;
        crc = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            fb  = data[i] ^ crc[4];
            crc = {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        crc = ~crc;
        return {crc[0], crc[1], crc[2], crc[3], crc[4]};
    endfunction

endpackage

// File: rtl/tx_line_enc.sv
// Transmit line stage: consecutive-ones counter for bit stuffing plus registered
// line outputs. NRZI coding of dout is enabled by defining SEND_TOKEN_NRZI_EN.
module tx_line_enc
    import usb_pkg::*;
#(
    parameter int STUFF_RUN = 6
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  line_sym_e sym,
    input  logic      bit_in,
    input  logic      first_bit,
    output logic      dout,
    output logic      se0,
    output logic      oe,
    output logic      stuff_req
);

    localparam int RUN_W = $clog2(STUFF_RUN + 1);

    logic [RUN_W-1:0] run_q, run_d;
    logic             level_q, level_d;
    logic             dout_q, dout_d;
    logic             se0_q, se0_d;
    logic             oe_q, oe_d;

    always_comb begin
        run_d   = run_q;
        level_d = level_q;
        dout_d  = dout_q;
        se0_d   = se0_q;
        oe_d    = oe_q;
        if (load) begin
            case (sym)
                SYM_BIT: begin
                    run_d   = bit_in ? run_q + RUN_W'(1) : '0;
                    // A packet always starts NRZI coding from the J level.
                    level_d = (first_bit ? 1'b1 : level_q) ^ ~bit_in;
`ifdef SEND_TOKEN_NRZI_EN
                    dout_d  = level_d;
`else
                    dout_d  = bit_in;
`endif
                    se0_d   = 1'b0;
                    oe_d    = 1'b1;
                end
                SYM_SE0: begin
                    run_d  = '0;
                    dout_d = 1'b0;
                    se0_d  = 1'b1;
                    oe_d   = 1'b1;
                end
                SYM_J: begin
                    run_d   = '0;
                    level_d = 1'b1;
                    dout_d  = 1'b1;
                    se0_d   = 1'b0;
                    oe_d    = 1'b1;
                end
                default: begin
                    run_d   = '0;
                    level_d = 1'b1;
                    dout_d  = 1'b1;
                    se0_d   = 1'b0;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q   <= '0;
            level_q <= 1'b1;
            dout_q  <= 1'b1;
            se0_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            run_q   <= run_d;
            level_q <= level_d;
            dout_q  <= dout_d;
            se0_q   <= se0_d;
            oe_q    <= oe_d;
        end
    end

    assign dout      = dout_q;
    assign se0       = se0_q;
    assign oe        = oe_q;
    assign stuff_req = (run_q == RUN_W'(STUFF_RUN));

endmodule

// File: rtl/send_token.sv
// Token packet transmitter: SYNC, PID, ADDR, ENDP, CRC5, EOP with bit stuffing.
// Build with SEND_TOKEN_NRZI_EN defined to NRZI-code dout inside tx_line_enc.
module send_token
    import usb_pkg::*;
#(
    parameter int SYNC_BITS = 8,
    parameter int STUFF_RUN = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en,
    input  logic       start_send_token,
    input  logic [3:0] pid,
    input  logic [6:0] addr,
    input  logic [3:0] endp,
    output logic       dout,
    output logic       se0,
    output logic       oe,
    output logic       busy,
    output logic       done_send_token
);

    localparam int FRAME_BITS = SYNC_BITS + 24;
    localparam int IDX_W      = $clog2(FRAME_BITS);

    // State names what is currently on the line; IDLE with busy set means a
    // packet is latched and waiting for its first bit strobe.
    tx_state_e               state_q, state_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    enc_load;
    line_sym_e               enc_sym;
    logic                    enc_bit;
    logic                    enc_first;
    logic                    stuff_req;
    logic                    last_bit;
    logic [SYNC_BITS-1:0]    sync_field;

    assign sync_field = {1'b1, {(SYNC_BITS-1){1'b0}}};
    assign last_bit   = (idx_q == IDX_W'(FRAME_BITS - 1));

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        enc_load  = 1'b0;
        enc_sym   = SYM_IDLE;
        enc_bit   = 1'b0;
        enc_first = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!busy_q) begin
                    if (start_send_token) begin
                        frame_d = {crc5({endp, addr}), endp, addr, ~pid, pid, sync_field};
                        idx_d   = '0;
                        busy_d  = 1'b1;
                    end
                end else if (bit_en) begin
                    state_d   = TX_SHIFT;
                    enc_load  = 1'b1;
                    enc_sym   = SYM_BIT;
                    enc_bit   = frame_q[0];
                    enc_first = 1'b1;
                end
            end
            TX_SHIFT, TX_STUFF: begin
                if (bit_en) begin
                    enc_load = 1'b1;
                    if (state_q == TX_SHIFT && stuff_req) begin
                        state_d = TX_STUFF;
                        enc_sym = SYM_BIT;
                        enc_bit = 1'b0;
                    end else if (last_bit) begin
                        state_d = TX_EOP0;
                        enc_sym = SYM_SE0;
                    end else begin
                        state_d = TX_SHIFT;
                        idx_d   = idx_q + IDX_W'(1);
                        enc_sym = SYM_BIT;
                        enc_bit = frame_q[idx_d];
                    end
                end
            end
            TX_EOP0: begin
                if (bit_en) begin
                    state_d  = TX_EOP1;
                    enc_load = 1'b1;
                    enc_sym  = SYM_SE0;
                end
            end
            TX_EOP1: begin
                if (bit_en) begin
                    state_d  = TX_EOP_J;
                    enc_load = 1'b1;
                    enc_sym  = SYM_J;
                end
            end
            TX_EOP_J: begin
                if (bit_en) begin
                    state_d  = TX_IDLE;
                    enc_load = 1'b1;
                    enc_sym  = SYM_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            frame_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    tx_line_enc #(
        .STUFF_RUN (STUFF_RUN)
    ) u_line_enc (
        .clk       (clk),
        .rst       (rst),
        .load      (enc_load),
        .sym       (enc_sym),
        .bit_in    (enc_bit),
        .first_bit (enc_first),
        .dout      (dout),
        .se0       (se0),
        .oe        (oe),
        .stuff_req (stuff_req)
    );

    assign busy            = busy_q;
    assign done_send_token = done_q;

endmodule

// File: tb/tb_send_token.sv
// Directed bench for send_token: captures the line one bit-time at a time and
// compares it with an independently built, stuffed expected stream.
module tb_send_token;
    import usb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_en;
    logic       start_send_token;
    logic [3:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
    logic       dout;
    logic       se0;
    logic       oe;
    logic       busy;
    logic       done_send_token;

    int vectors     = 0;
    int miscompares = 0;

    // Captured / expected symbols: 2'b0x = data bit x (J = 2'b01), 2'b10 = SE0.
    logic [1:0] cap [0:79];
    logic [1:0] exp_s [0:79];
    logic       raw_lvl [0:79];
    int         cap_n;
    int         exp_n;
    int         exp_stuffed;
    int         first_c;
    int         done_c;
    int         done_w;
    int         hold_err;
    logic       busy_seen;
    bit         timed_out;

`ifdef SEND_TOKEN_NRZI_EN
    localparam bit         NRZI         = 1'b1;
    localparam logic [7:0] EXP_RAW_SYNC = 8'b01010100;
`else
    localparam bit         NRZI         = 1'b0;
    localparam logic [7:0] EXP_RAW_SYNC = 8'b00000001;
`endif

    send_token dut (
        .clk              (clk),
        .rst              (rst),
        .bit_en           (bit_en),
        .start_send_token (start_send_token),
        .pid              (pid),
        .addr             (addr),
        .endp             (endp),
        .dout             (dout),
        .se0              (se0),
        .oe               (oe),
        .busy             (busy),
        .done_send_token  (done_send_token)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

    // crc_tx holds the CRC bits in wire order, first transmitted bit as MSB.
    task automatic build_expected(input logic [3:0] p, input logic [6:0] a,
                                  input logic [3:0] e, input logic [4:0] crc_tx);
        logic [31:0] f;
        int          run;
        f    = 32'h0;
        f[7] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f[8+i]  = p[i];
            f[12+i] = ~p[i];
        end
        for (int i = 0; i < 7; i++) f[16+i] = a[i];
        for (int i = 0; i < 4; i++) f[23+i] = e[i];
        for (int i = 0; i < 5; i++) f[27+i] = crc_tx[4-i];
        exp_n       = 0;
        run         = 0;
        exp_stuffed = 0;
        for (int i = 0; i < 32; i++) begin
            exp_s[exp_n] = {1'b0, f[i]};
            exp_n++;
            if (f[i]) run++;
            else run = 0;
            if (run == 6) begin
                exp_s[exp_n] = 2'b00;
                exp_n++;
                run = 0;
                exp_stuffed++;
            end
        end
        exp_s[exp_n]   = 2'b10;
        exp_s[exp_n+1] = 2'b10;
        exp_s[exp_n+2] = 2'b01;
        exp_n += 3;
    endtask

    function automatic int first_diff();
        if (cap_n != exp_n) return 999;
        for (int i = 0; i < exp_n; i++) if (cap[i] !== exp_s[i]) return i;
        return -1;
    endfunction

    task automatic run_packet(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                              input int period, input int mid_start_c);
        bit         prev_en;
        bit         in_data;
        logic       lvl;
        logic [2:0] last_out;
        cap_n = 0; first_c = -1; done_c = -1; done_w = 0; hold_err = 0; timed_out = 1'b1;
        @(negedge clk);
        pid = p; addr = a; endp = e; start_send_token = 1'b1; bit_en = 1'b0;
        @(negedge clk);
        busy_seen = busy;
        start_send_token = 1'b0; pid = ~p; addr = ~a; endp = ~e;
        last_out = {dout, se0, oe};
        for (int c = 0; c < 600; c++) begin
            bit_en = (c % period == 0);
            start_send_token = (c == mid_start_c);
            if (c == mid_start_c) pid = PID_SETUP;
            prev_en = bit_en;
            @(negedge clk);
            if (!prev_en && {dout, se0, oe} !== last_out) hold_err++;
            last_out = {dout, se0, oe};
            if (done_send_token) begin
                done_w++;
                if (done_c < 0) done_c = c;
            end else if (done_w > 0) begin
                timed_out = 1'b0;
                break;
            end
            if (prev_en && oe && cap_n < 80) begin
                if (first_c < 0) first_c = c;
                cap[cap_n] = se0 ? 2'b10 : {1'b0, dout};
                cap_n++;
            end
        end
        bit_en = 1'b0; start_send_token = 1'b0;
        for (int i = 0; i < cap_n; i++) raw_lvl[i] = cap[i][0];
        if (NRZI) begin
            lvl = 1'b1; in_data = 1'b1;
            for (int i = 0; i < cap_n; i++) begin
                if (cap[i][1]) in_data = 1'b0;
                if (in_data) begin
                    cap[i] = {1'b0, cap[i][0] == lvl};
                    lvl    = raw_lvl[i];
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst = 1'b1; bit_en = 1'b0; start_send_token = 1'b0; pid = 4'h0; addr = 7'h0; endp = 4'h0;
        repeat (3) @(negedge clk);
        obs = {dout, se0, oe, busy, done_send_token};
        rst = 1'b0;
        vectors++; if (obs[4] !== 1'b1) begin miscompares++; $display("FAIL reset_dout got %b want 1", obs[4]); end
        vectors++; if (obs[3] !== 1'b0) begin miscompares++; $display("FAIL reset_se0 got %b want 0", obs[3]); end
        vectors++; if (obs[2] !== 1'b0) begin miscompares++; $display("FAIL reset_oe got %b want 0", obs[2]); end
        vectors++; if (obs[1] !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", obs[1]); end
        vectors++; if (obs[0] !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", obs[0]); end
        $display("reset: dout=%b se0=%b oe=%b busy=%b done=%b", obs[4], obs[3], obs[2], obs[1], obs[0]);
    endtask

    task automatic test_out_packet();
        logic [4:0] crc_f;
        logic [7:0] sync_f;
        logic [7:0] sync_raw;
        int         d;
        build_expected(PID_OUT, 7'h00, 4'h0, 5'b01000);
        run_packet(PID_OUT, 7'h00, 4'h0, 1, -1);
        d = first_diff();
        for (int i = 0; i < 5; i++) crc_f[i] = cap[27+i][0];
        for (int i = 0; i < 8; i++) sync_f[i] = cap[i][0];
        sync_raw = 8'h0;
        for (int i = 0; i < 8; i++) sync_raw = {sync_raw[6:0], raw_lvl[i]};
        vectors++; if (timed_out) begin miscompares++; $display("FAIL out_timeout no done within bound"); end
        vectors++; if (busy_seen !== 1'b1) begin miscompares++; $display("FAIL out_busy_t1 got %b want 1", busy_seen); end
        vectors++; if (d != -1) begin miscompares++; $display("FAIL out_stream first diff at %0d len %0d want len %0d", d, cap_n, exp_n); end
        vectors++; if (cap_n != 35) begin miscompares++; $display("FAIL out_nostuff bit-times %0d want 35", cap_n); end
        vectors++; if (done_w != 1) begin miscompares++; $display("FAIL out_done_width got %0d want 1", done_w); end
        vectors++; if (done_c - first_c != 35) begin miscompares++; $display("FAIL out_latency got %0d want 35", done_c - first_c); end
        vectors++; if (crc_f !== 5'h02) begin miscompares++; $display("FAIL out_crc_field got %h want 02", crc_f); end
        vectors++; if (sync_f !== SYNC_PATTERN) begin miscompares++; $display("FAIL out_sync got %h want %h", sync_f, SYNC_PATTERN); end
        vectors++; if (sync_raw !== EXP_RAW_SYNC) begin miscompares++; $display("FAIL out_sync_line got %b want %b", sync_raw, EXP_RAW_SYNC); end
        vectors++; if ({busy, oe} !== 2'b00) begin miscompares++; $display("FAIL out_after_done busy,oe got %b want 00", {busy, oe}); end
        $display("out addr=00 endp=0: bits=%0d latency=%0d done_w=%0d crc=%h", cap_n, done_c - first_c, done_w, crc_f);
    endtask

    task automatic test_crc();
        logic [3:0]  t_pid [0:1];
        logic [6:0]  t_addr [0:1];
        logic [3:0]  t_endp [0:1];
        logic [4:0]  t_crc [0:1];
        logic [4:0]  crc_w;
        int          d;
        // CRC values written in the customary MSB-first-on-the-wire form.
        t_pid[0] = PID_OUT; t_addr[0] = 7'h15; t_endp[0] = 4'hE; t_crc[0] = 5'h17;
        t_pid[1] = PID_IN;  t_addr[1] = 7'h3A; t_endp[1] = 4'hA; t_crc[1] = 5'h1C;
        for (int v = 0; v < 2; v++) begin
            build_expected(t_pid[v], t_addr[v], t_endp[v], t_crc[v]);
            run_packet(t_pid[v], t_addr[v], t_endp[v], 1, -1);
            d = first_diff();
            crc_w = 5'h0;
            for (int i = 0; i < 5; i++) crc_w = {crc_w[3:0], cap[27+i][0]};
            vectors++; if (crc_w !== t_crc[v]) begin miscompares++; $display("FAIL crc_%0d got %h want %h", v, crc_w, t_crc[v]); end
            vectors++; if (d != -1) begin miscompares++; $display("FAIL crc_stream_%0d first diff at %0d", v, d); end
            $display("crc addr=%h endp=%h: crc=%h bits=%0d", t_addr[v], t_endp[v], crc_w, cap_n);
        end
    endtask

    task automatic test_stuffing();
        int d;
        build_expected(PID_IN, 7'h7F, 4'hF, 5'b00010);
        run_packet(PID_IN, 7'h7F, 4'hF, 1, -1);
        d = first_diff();
        vectors++; if ({cap[21], cap[22], cap[23]} !== 6'b01_00_01) begin miscompares++; $display("FAIL stuff_position got %b want 010001", {cap[21], cap[22], cap[23]}); end
        vectors++; if (cap_n - 35 != exp_stuffed) begin miscompares++; $display("FAIL stuff_count got %0d want %0d", cap_n - 35, exp_stuffed); end
        vectors++; if (done_c - first_c != 35 + exp_stuffed) begin miscompares++; $display("FAIL stuff_length got %0d want %0d", done_c - first_c, 35 + exp_stuffed); end
        vectors++; if (d != -1) begin miscompares++; $display("FAIL stuff_stream first diff at %0d", d); end
        $display("stuff pid=IN addr=7F endp=F: bits=%0d stuffed=%0d", cap_n, cap_n - 35);
    endtask

    task automatic test_slow_bit_en();
        int d;
        int extra;
        build_expected(PID_OUT, 7'h15, 4'hE, 5'h17);
        run_packet(PID_OUT, 7'h15, 4'hE, 4, 40);
        d = first_diff();
        extra = 0;
        bit_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (oe || busy || done_send_token) extra++;
        end
        bit_en = 1'b0;
        vectors++; if (d != -1) begin miscompares++; $display("FAIL slow_stream first diff at %0d", d); end
        vectors++; if (done_w != 1) begin miscompares++; $display("FAIL slow_done_width got %0d want 1", done_w); end
        vectors++; if (hold_err != 0) begin miscompares++; $display("FAIL slow_hold changes between strobes %0d want 0", hold_err); end
        vectors++; if (done_c - first_c != 140) begin miscompares++; $display("FAIL slow_latency got %0d want 140", done_c - first_c); end
        vectors++; if (extra != 0) begin miscompares++; $display("FAIL slow_mid_start activity after done %0d want 0", extra); end
        $display("slow bit_en/4: bits=%0d latency=%0d done_w=%0d", cap_n, done_c - first_c, done_w);
    endtask

    task automatic test_abort();
        logic [3:0] obs;
        int         stray;
        int         d;
        @(negedge clk);
        pid = PID_OUT; addr = 7'h3A; endp = 4'hA; start_send_token = 1'b1; bit_en = 1'b1;
        @(negedge clk);
        start_send_token = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        obs = {oe, dout, busy, done_send_token};
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done_send_token || oe || busy) stray++;
        end
        bit_en = 1'b0;
        vectors++; if (obs[3] !== 1'b0) begin miscompares++; $display("FAIL abort_oe got %b want 0", obs[3]); end
        vectors++; if (obs[2] !== 1'b1) begin miscompares++; $display("FAIL abort_dout got %b want 1", obs[2]); end
        vectors++; if (obs[1] !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", obs[1]); end
        vectors++; if (obs[0] !== 1'b0 || stray != 0) begin miscompares++; $display("FAIL abort_no_done done=%b stray=%0d want 0/0", obs[0], stray); end
        build_expected(PID_OUT, 7'h3A, 4'hA, 5'h1C);
        run_packet(PID_OUT, 7'h3A, 4'hA, 1, -1);
        d = first_diff();
        vectors++; if (d != -1 || done_w != 1) begin miscompares++; $display("FAIL abort_resend diff at %0d done_w %0d want -1/1", d, done_w); end
        $display("abort in ADDR: oe=%b dout=%b busy=%b done=%b, resend bits=%0d", obs[3], obs[2], obs[1], obs[0], cap_n);
    endtask

    initial begin
        test_reset();
        test_out_packet();
        test_crc();
        test_stuffing();
        test_slow_bit_en();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/send_token.md
Name: send_token

Overview:
- Serializes one host token packet (SYNC, PID, ADDR, ENDP, CRC5, EOP) onto the bus transmit path, one bit per bit-time strobe.
- Sits directly downstream of the transaction controller FSM, which raises start_send_token.
- Returns a one-cycle done_send_token pulse, which advances that FSM to its data-send or data-receive phase.
- Performs CRC5 generation and bit stuffing. NRZI line coding is optional.

Parameters:
- SYNC_BITS, 8, length of the SYNC field; the pattern is SYNC_BITS-1 zeros then a single one.
- STUFF_RUN, 6, number of consecutive transmitted ones after which a zero is inserted.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- bit_en  in  1  bit-time strobe; all line activity advances only on cycles where bit_en=1.
- start_send_token  in  1  request, sampled only in IDLE.
- pid  in  4  token PID nibble (OUT=4'b0001, IN=4'b1001, SETUP=4'b1101).
- addr  in  7  device address.
- endp  in  4  endpoint number.
- dout  out  1  line bit; idle/J = 1.
- se0  out  1  high during the EOP SE0 bit-times.
- oe  out  1  transmitter drive enable.
- busy  out  1  high from the accepted start until done.
- done_send_token  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at posedge), regardless of current state:
  - state=IDLE, dout=1, se0=0, oe=0, busy=0, done_send_token=0, stuff counter=0.
  - No done pulse is generated for an aborted packet.
- Start handshake:
  - In IDLE, start_send_token=1 at edge T latches pid/addr/endp. busy=1 from T+1.
  - start_send_token is ignored while busy.
  - Inputs may change after T without effect.
- Frame:
  - A 32-bit frame is built at start: SYNC(8), PID(8) = {~pid,pid}, ADDR(7), ENDP(4), CRC5(5).
  - All fields are sent LSB first.
  - CRC5 covers the 11 bits {endp,addr}: polynomial x^5+x^2+1, seed 5'b11111, result inverted.
  - Packed field value for addr=0, endp=0 is 5'h02.
- States: IDLE -> SHIFT -> (STUFF <-> SHIFT) -> EOP0 -> EOP1 -> EOP_J -> IDLE.
  - Transitions out of SHIFT, STUFF and EOP* occur only on bit_en.
  - SHIFT: oe=1, drive the next frame bit, increment bit index 0..31.
  - STUFF: drive 0 without consuming a frame bit.
  - EOP0/EOP1: se0=1, oe=1.
  - EOP_J: se0=0, dout=1 (J), oe=1.
  - On leaving EOP_J: oe=0, busy=0, done_send_token=1 for exactly one clk cycle (not one bit-time). Return to IDLE.
- The first SYNC bit appears on the first bit_en at or after T+1. bit_en held 1 continuously gives one bit per clk.
- Bit stuffing:
  - Run counter increments on each transmitted 1 and clears on any transmitted 0, including stuffed zeros.
  - SYNC participates.
  - When the counter reaches STUFF_RUN, the next bit-time is STUFF.
  - If the run completes on the last CRC bit, the stuffed 0 is still sent before EOP0.
- Total bit-times per packet = 32 + stuffed bits + 3.
- Outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro SEND_TOKEN_NRZI_EN.
- Defined: dout is NRZI-coded. A transmitted 0 toggles the line, a 1 holds it.
  - Line level is forced to 1 (J) at the start of SYNC and again at EOP_J.
  - se0 overrides dout.
- Undefined: dout carries the raw stuffed NRZ bit stream; downstream handles line coding.
- Stuffing, timing and done behaviour are identical in both builds.

Decomposition:
- Shared package usb_pkg holds:
  - PID constants (PID_OUT, PID_IN, PID_SETUP).
  - The SYNC pattern.
  - A tx state enum.
  - The crc5 function, also used by the token receiver checker.
- One natural sub-module, tx_line_enc: the bit-stuff counter plus the optional NRZI stage. It is reusable by send_data and send_hand.

Test Plan:
- pid=OUT, addr=0, endp=0, bit_en=1 constant:
  - Bit stream = 00000001, then 10000111 (PID), 7 zeros, 4 zeros, CRC 01000, then SE0, SE0, J.
  - done_send_token pulses exactly 1 cycle, 35 cycles after the first bit; no stuffing.
- addr=7'h15, endp=4'hE -> CRC field 5'h17; addr=7'h3A, endp=4'hA -> CRC field 5'h1C.
- pid=IN, addr=7'h7F, endp=4'hF:
  - A stuffed 0 appears immediately after addr[5].
  - Packet length = 32 + stuffed count + 3 bit-times, with the stuffed count checked against the reference model.
- bit_en asserted every 4th cycle:
  - Each bit is held 4 cycles.
  - done_send_token is still 1 cycle wide.
  - A second start_send_token asserted mid-packet is ignored.
- rst=1 during the ADDR field:
  - Next cycle: oe=0, dout=1, busy=0, no done pulse.
  - A following start sends a full, correct packet.
- With SEND_TOKEN_NRZI_EN: the OUT/addr0/endp0 packet's SYNC appears on dout as 01010100.
